bound_vpad_gen: RTL and testbench

//  Next-generation top/bottom border generator for the kernel-window front end (Sobel and similar filters).

---
 rtl/bound_vpad_gen_if.sv | 19 +
 rtl/bound_vpad_gen.sv | 194 +++++++++++++++++++
 tb/tb_bound_vpad_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bound_vpad_gen_if.sv
// bound_vpad_gen_if: video stream bundle for the top/bottom border generator.
//   din_vsync/din_hsync/din     : source frame valid, line valid, pixel
//   dout_vsync/dout_hsync/dout  : padded frame valid, line valid, pixel
//   frame_drop                  : 1-cycle pulse when an input frame is rejected
// W is the pixel width (CH*DW of the generator).
interface bound_vpad_gen_if #(parameter int W = 8);
  logic         din_vsync;
  logic         din_hsync;
  logic [W-1:0] din;
  logic         dout_vsync;
  logic         dout_hsync;
  logic [W-1:0] dout;
  logic         frame_drop;

  modport master (output din_vsync, din_hsync, din,
                  input  dout_vsync, dout_hsync, dout, frame_drop);
  modport slave  (input  din_vsync, din_hsync, din,
                  output dout_vsync, dout_hsync, dout, frame_drop);
endinterface

// File: rtl/bound_vpad_gen.sv
// bound_vpad_gen: adds PAD=(KSZ-1)/2 rows above and below a CH-channel video
// frame. Pad rows are FILL (MODE 0) or a copy of the nearest edge row (MODE 1).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bound_vpad_gen_if.slave (din_* in, dout_*/frame_drop out)
// Output row k appears (k+1)*H_TOTAL clocks after the first input line of the
// frame; input rows are held in a (PAD+2)-slot ring until their output turn.

// One channel of the output register: selects ring data or fill, zero when idle.
module bound_vpad_lane #(parameter int DW = 8) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fill_sel,
  input  logic [DW-1:0] px,
  input  logic [DW-1:0] fill,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)      q <= '0;
    else if (!en) q <= '0;
    else          q <= fill_sel ? fill : px;
endmodule

module bound_vpad_gen #(
  parameter int            KSZ         = 5,
  parameter int            DW          = 8,
  parameter int            CH          = 1,
  parameter int            IW          = 4,
  parameter int            IH          = 2,
  parameter int            H_TOTAL     = 6,
  parameter int            V_FRONT_CLK = 3,
  parameter int            MODE        = 0,
  parameter logic [DW-1:0] FILL        = '0
) (
  input logic             clk,
  input logic             rst,
  bound_vpad_gen_if.slave bus
);
  localparam int PAD   = (KSZ - 1) / 2;
  localparam int NSLOT = PAD + 2;
  localparam int NROWS = IH + 2 * PAD;
  localparam int TW    = $clog2(H_TOTAL + 1);
  localparam int LW    = $clog2(NROWS + 2);
  localparam int RW    = $clog2(IH + 2);
  localparam int XW    = $clog2(IW + 1);
  localparam int SW    = $clog2(NSLOT);
  localparam int FW    = $clog2(V_FRONT_CLK + 2);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, RUN, FRONT} state_t;

  state_t          state;
  logic            vs_q, hs_q, cap_en;
  logic [SW-1:0]   wr_slot;
  logic [XW-1:0]   wr_col;
  logic [RW-1:0]   rows_cap;    // rows fully captured in this frame
  logic [TW-1:0]   tcnt;        // clock within line period, counted from S
  logic [LW-1:0]   line;        // line periods elapsed since S
  logic [FW-1:0]   fcnt;
  logic            dout_vsync_r, dout_hsync_r, frame_drop_r;

  // Ring depth/width rounded up to powers of two so counters index it directly.
  logic [CH*DW-1:0] ring [0:(1<<SW)-1][0:(1<<XW)-1];

  logic vs_rise, vs_fall, hs_rise, hs_fall, wr_en, row_done;
  assign vs_rise = bus.din_vsync & ~vs_q;
  assign vs_fall = ~bus.din_vsync & vs_q;
  assign hs_rise = bus.din_hsync & ~hs_q;
  assign hs_fall = ~bus.din_hsync & hs_q;

  // The first line is written on the same edge that moves WAIT_LINE to RUN.
  assign wr_en = cap_en && bus.din_hsync && (rows_cap < RW'(IH)) &&
                 (wr_col < XW'(IW)) &&
                 ((state == RUN) || ((state == WAIT_LINE) && hs_rise));
  assign row_done = cap_en && hs_fall && (wr_col != '0) && (rows_cap < RW'(IH));

  always_ff @(posedge clk)
    if (wr_en) ring[wr_slot][wr_col] <= bus.din;

  // Read side: line L carries output row k=L-1, source row j=k-PAD.
  // Rows not (yet) captured -- bottom pad or an underrun -- fall back to the
  // last captured row in MODE 1, or to FILL in MODE 0.
  logic          out_en, fill_sel;
  logic [SW-1:0] rd_slot;
  int            rd_j, rd_src;

  always_comb begin
    rd_j     = int'(line) - 1 - PAD;
    rd_src   = 0;
    fill_sel = 1'b0;
    out_en   = (state == RUN) && (line != '0) && (line <= LW'(NROWS)) &&
               (tcnt < TW'(IW));
    if (rd_j < 0) begin
      fill_sel = (MODE == 0) || (rows_cap == '0);
    end else if (rd_j >= int'(rows_cap)) begin
      rd_src   = (rows_cap == '0) ? 0 : int'(rows_cap) - 1;
      fill_sel = (MODE == 0) || (rows_cap == '0);
    end else begin
      rd_src   = rd_j;
    end
    rd_slot = SW'(rd_src % NSLOT);
  end

  logic [CH-1:0][DW-1:0] rd_px_v, dout_v;
  assign rd_px_v = ring[rd_slot][XW'(tcnt)];

  for (genvar g = 0; g < CH; g++) begin : g_lane
    bound_vpad_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (out_en),
      .fill_sel(fill_sel),
      .px      (rd_px_v[g]),
      .fill    (FILL),
      .q       (dout_v[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      cap_en       <= 1'b0;
      wr_slot      <= '0;
      wr_col       <= '0;
      rows_cap     <= '0;
      tcnt         <= '0;
      line         <= '0;
      fcnt         <= '0;
      dout_vsync_r <= 1'b0;
      dout_hsync_r <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      vs_q         <= bus.din_vsync;
      hs_q         <= bus.din_hsync;
      dout_hsync_r <= out_en;
      frame_drop_r <= vs_rise && (state != IDLE);

      if (wr_en) wr_col <= wr_col + 1'b1;
      if (row_done) begin
        rows_cap <= rows_cap + 1'b1;
        wr_slot  <= (wr_slot == SW'(NSLOT - 1)) ? '0 : wr_slot + 1'b1;
        wr_col   <= '0;
      end
      // A frame whose vsync ends stops capturing; the output keeps running.
      if (vs_fall) cap_en <= 1'b0;

      case (state)
        IDLE: if (vs_rise) begin
          state        <= WAIT_LINE;
          dout_vsync_r <= 1'b1;
          cap_en       <= 1'b1;
          wr_slot      <= '0;
          wr_col       <= '0;
          rows_cap     <= '0;
        end
        // A frame that ends before any line produces no rows.
        WAIT_LINE: if (vs_fall) begin
          state        <= IDLE;
          dout_vsync_r <= 1'b0;
        end else if (hs_rise) begin
          state <= RUN;
          tcnt  <= TW'(1);
          line  <= '0;
        end
        RUN: begin
          if (tcnt == TW'(H_TOTAL - 1)) begin
            tcnt <= '0;
            line <= line + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          if ((line == LW'(NROWS)) && (tcnt == TW'(IW))) begin
            state <= FRONT;
            fcnt  <= FW'(1);
          end
        end
        FRONT: if (fcnt >= FW'(V_FRONT_CLK)) begin
          state        <= IDLE;
          dout_vsync_r <= 1'b0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout_vsync = dout_vsync_r;
  assign bus.dout_hsync = dout_hsync_r;
  assign bus.frame_drop = frame_drop_r;
  assign bus.dout       = dout_v;
endmodule

// File: tb/tb_bound_vpad_gen.sv
// Bench for bound_vpad_gen: three instances share one stimulus stream
//   d0: KSZ5 MODE1 CH1, d1: KSZ5 MODE0 FILL0 CH1, d2: KSZ3 MODE1 CH3.
// Expected pixels (with their output cycle) are queued per instance when a
// frame is driven and popped as each instance raises dout_hsync.
module tb_bound_vpad_gen;
  localparam int IW = 4, H = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic vs = 1'b0, hs = 1'b0;
  logic [23:0] din = '0;
  int cyc = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bound_vpad_gen_if #(.W(8))  ia ();
  bound_vpad_gen_if #(.W(8))  ib ();
  bound_vpad_gen_if #(.W(24)) ic ();

  assign ia.din_vsync = vs; assign ia.din_hsync = hs; assign ia.din = din[7:0];
  assign ib.din_vsync = vs; assign ib.din_hsync = hs; assign ib.din = din[7:0];
  assign ic.din_vsync = vs; assign ic.din_hsync = hs; assign ic.din = din;

  bound_vpad_gen #(.KSZ(5), .DW(8), .CH(1), .IW(IW), .IH(2), .H_TOTAL(H),
                   .V_FRONT_CLK(3), .MODE(1), .FILL(8'h00))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  bound_vpad_gen #(.KSZ(5), .DW(8), .CH(1), .IW(IW), .IH(2), .H_TOTAL(H),
                   .V_FRONT_CLK(3), .MODE(0), .FILL(8'h00))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  bound_vpad_gen #(.KSZ(3), .DW(8), .CH(3), .IW(IW), .IH(2), .H_TOTAL(H),
                   .V_FRONT_CLK(3), .MODE(1), .FILL(8'h00))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct { int cyc; logic [23:0] px; } exp_t;
  exp_t qa[$], qb[$], qc[$];

  logic [23:0] img [2][4];
  bit prev_vs [3];
  int last_rise [3], last_fall [3], drops [3], drop_cyc [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: output row k takes source row j=k-pad, clamped to the rows
  // actually sent; MODE0 instance fills out-of-range rows with zero.
  task automatic push_exp(input int s, input int nr);
    for (int d = 0; d < 3; d++) begin
      int pad;
      bit rep;
      pad = (d == 2) ? 1 : 2;
      rep = (d != 1);
      for (int k = 0; k < 2 + 2 * pad; k++) begin
        int j, src;
        bit fill;
        j    = k - pad;
        src  = (j < 0) ? 0 : (j >= nr) ? nr - 1 : j;
        fill = !rep && ((j < 0) || (j >= nr));
        for (int c = 0; c < IW; c++) begin
          exp_t e;
          logic [23:0] v;
          v     = img[src][c];
          e.cyc = s + (k + 1) * H + c;
          e.px  = fill ? 24'h0 : (d == 2) ? v : {16'h0, v[7:0]};
          case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
          endcase
        end
      end
    end
  endtask

  task automatic mon(input int d, input logic h, input logic v, input logic fd,
                     input logic [23:0] px);
    exp_t e;
    int n;
    case (d)
      0: n = qa.size();
      1: n = qb.size();
      default: n = qc.size();
    endcase
    if (h) begin
      if (n == 0) chk($sformatf("d%0d_unexpected_hsync", d), 32'(h), 32'd0);
      else begin
        case (d)
          0: e = qa.pop_front();
          1: e = qb.pop_front();
          default: e = qc.pop_front();
        endcase
        chk($sformatf("d%0d_px_cycle", d), cyc, e.cyc);
        chk($sformatf("d%0d_px_value@%0d", d, e.cyc), 32'(px), 32'(e.px));
      end
    end else chk($sformatf("d%0d_idle_dout", d), 32'(px), 32'd0);
    if (v && !prev_vs[d]) last_rise[d] = cyc;
    if (!v && prev_vs[d]) last_fall[d] = cyc;
    if (fd) begin drops[d]++; drop_cyc[d] = cyc; end
    prev_vs[d] = v;
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, ia.dout_hsync, ia.dout_vsync, ia.frame_drop, {16'h0, ia.dout});
    mon(1, ib.dout_hsync, ib.dout_vsync, ib.frame_drop, {16'h0, ib.dout});
    mon(2, ic.dout_hsync, ic.dout_vsync, ic.frame_drop, ic.dout);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one frame of nr rows; s = edge that samples the first line.
  task automatic send(input int nr, output int s);
    step(); vs = 1'b1;
    step();
    s = cyc + 1;
    push_exp(s, nr);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < H; c++) begin
        hs  = (c < IW);
        din = (c < IW) ? img[r][c] : 24'h0;
        step();
      end
    hs = 1'b0; din = '0; vs = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      done = (qa.size() == 0) && (qb.size() == 0) && (qc.size() == 0) &&
             !ia.dout_vsync && !ib.dout_vsync && !ic.dout_vsync;
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
    repeat (3) step();
  endtask

  task automatic chk_falls(input string tag, input int s);
    chk({tag, "_d0_vs_fall"}, last_fall[0], s + 6 * H + IW + 3);
    chk({tag, "_d1_vs_fall"}, last_fall[1], s + 6 * H + IW + 3);
    chk({tag, "_d2_vs_fall"}, last_fall[2], s + 4 * H + IW + 3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vs"}, 32'({ia.dout_vsync, ib.dout_vsync, ic.dout_vsync}), 32'd0);
    chk({tag, "_hs"}, 32'({ia.dout_hsync, ib.dout_hsync, ic.dout_hsync}), 32'd0);
    chk({tag, "_dout"}, 32'(ia.dout | ib.dout | ic.dout[7:0] | ic.dout[23:8]), 32'd0);
    chk({tag, "_drop"}, 32'({ia.frame_drop, ib.frame_drop, ic.frame_drop}), 32'd0);
  endtask

  initial begin
    int s, d0, d1, d2;
    logic [7:0] r8 [2][4];
    r8[0] = '{8'd20, 8'd18, 8'd32, 8'd11};
    r8[1] = '{8'd51, 8'd33, 8'd67, 8'd2};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = {8'(r * 16 + c + 1), 8'(r * 16 + c + 8), r8[r][c]};

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk_zero("reset");
    step(); rst = 1'b0;
    repeat (3) step();

    // Full frame: MODE1 edge replicate, MODE0 zero fill, KSZ3 three channels
    d0 = drops[0]; d1 = drops[1]; d2 = drops[2];
    send(2, s);
    drain("frame");
    chk("frame_d0_vs_rise", last_rise[0], s - 1);
    chk("frame_d2_vs_rise", last_rise[2], s - 1);
    chk_falls("frame", s);
    chk("frame_no_drop", drops[0] + drops[1] + drops[2], d0 + d1 + d2);

    // Overlapping frame: second vsync rise at S+20 while output is busy
    d0 = drops[0]; d1 = drops[1]; d2 = drops[2];
    send(2, s);
    while (cyc < s + 19) step();
    vs = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < H; c++) begin
        hs  = (c < IW);
        din = (c < IW) ? 24'hEEEEEE : 24'h0;
        step();
      end
    hs = 1'b0; din = '0; vs = 1'b0;
    drain("overlap");
    chk("overlap_d0_drops", drops[0] - d0, 1);
    chk("overlap_d1_drops", drops[1] - d1, 1);
    chk("overlap_d2_drops", drops[2] - d2, 1);
    chk("overlap_d0_drop_cyc", drop_cyc[0], s + 20);
    chk("overlap_d2_drop_cyc", drop_cyc[2], s + 20);
    chk_falls("overlap", s);

    // Reset during output row 3, then a clean frame must match exactly
    send(2, s);
    while (cyc < s + 25) step();
    rst = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    @(negedge clk);
    chk_zero("midreset");
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    send(2, s);
    drain("after_reset");
    chk_falls("after_reset", s);

    // Underrun: one row only, vsync falls early
    send(1, s);
    drain("underrun");
    chk_falls("underrun", s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
